dcache_ctrl: RTL and testbench

//  Direct-mapped, write-back, write-allocate data cache with its miss controller. Sits between the

---
 rtl/dcache_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache with its miss controller.
// Hits are served combinationally. A miss stalls the core, writes back a dirty
// victim word by word, refills the line word by word, and then releases the stall.
// Valid/ready on the memory side: a beat is offered while mem_req is high, and
// mem_req/mem_we/mem_addr/mem_wdata are held stable until the cycle in which
// mem_ack is sampled high. mem_ack is ignored while mem_req is low.
module dcache_ctrl #(
    parameter int WD         = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [WD-1:0] cpu_addr,
    input  logic [WD-1:0] cpu_wdata,
    output logic [WD-1:0] cpu_rdata,
    output logic          stall,
    output logic          mem_req,
    output logic          mem_we,
    output logic [WD-1:0] mem_addr,
    output logic [WD-1:0] mem_wdata,
    input  logic [WD-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [15:0]   hit_cnt,
    output logic [15:0]   miss_cnt,
    output logic [1:0]    state_dbg
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = WD - 2 - OFF_W - IDX_W;
    localparam logic [OFF_W-1:0] BEAT_LAST = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WBACK = 2'd1, S_FILL = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [OFF_W-1:0]     beat_q, beat_d;
    logic                 mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [WD-1:0]        mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic [SETS-1:0]      valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [SETS];
    logic [WD-1:0]        data_q [SETS*LINE_WORDS];
    logic [IDX_W-1:0]     miss_idx_q;
    logic [TAG_W-1:0]     miss_tag_q;
    logic [15:0]          hit_cnt_q, miss_cnt_q;

    logic [OFF_W-1:0]     cpu_off;
    logic [IDX_W-1:0]     cpu_idx, cur_idx;
    logic [TAG_W-1:0]     cpu_tag, fill_tag;
    logic                 hit, idle, hit_acc, miss_acc, ack_ok, last_beat;
    logic                 unused_byte;

    assign cpu_off     = cpu_addr[2 +: OFF_W];
    assign cpu_idx     = cpu_addr[2 + OFF_W +: IDX_W];
    assign cpu_tag     = cpu_addr[WD-1 -: TAG_W];
    assign unused_byte = ^cpu_addr[1:0];

    assign idle     = (state_q == S_IDLE);
    assign hit      = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
    assign hit_acc  = idle && cpu_req && hit;
    assign miss_acc = idle && cpu_req && !hit;
    assign ack_ok   = mem_req_q && mem_ack;
    assign last_beat = (beat_q == BEAT_LAST);

    // The miss line is taken from the core address in the miss cycle and from
    // the latched copy afterwards, so the core may change or drop its request.
    assign cur_idx  = idle ? cpu_idx : miss_idx_q;
    assign fill_tag = idle ? cpu_tag : miss_tag_q;

    assign cpu_rdata = hit ? data_q[{cpu_idx, cpu_off}] : '0;
    assign stall     = !idle || (cpu_req && !hit);
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign hit_cnt   = hit_cnt_q;
    assign miss_cnt  = miss_cnt_q;
    assign state_dbg = state_q;

    // State register, beat counter and registered bus outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Next state: leave IDLE on a miss, advance one beat per accepted ack.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            S_IDLE: begin
                if (miss_acc) begin
                    beat_d  = '0;
                    state_d = (valid_q[cpu_idx] && dirty_q[cpu_idx]) ? S_WBACK : S_FILL;
                end
            end
            S_WBACK: begin
                if (ack_ok) begin
                    if (last_beat) begin
                        state_d = S_FILL;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            S_FILL: begin
                if (ack_ok) begin
                    if (last_beat) begin
                        state_d = S_IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Bus outputs for the beat the next state will present; they only change on an ack.
    always_comb begin
        mem_req_d   = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_d)
            S_WBACK: begin
                mem_req_d   = 1'b1;
                mem_we_d    = 1'b1;
                mem_addr_d  = {tag_q[cur_idx], cur_idx, beat_d, 2'b00};
                mem_wdata_d = data_q[{cur_idx, beat_d}];
            end
            S_FILL: begin
                mem_req_d  = 1'b1;
                mem_addr_d = {fill_tag, cur_idx, beat_d, 2'b00};
            end
            default: ;
        endcase
    end

    // Line status, miss bookkeeping and saturating hit/miss counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q    <= '0;
            dirty_q    <= '0;
            miss_idx_q <= '0;
            miss_tag_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (miss_acc) begin
                miss_idx_q       <= cpu_idx;
                miss_tag_q       <= cpu_tag;
                valid_q[cpu_idx] <= 1'b0;
                dirty_q[cpu_idx] <= 1'b0;
                if (miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
            end
            if (hit_acc) begin
                if (cpu_we) dirty_q[cpu_idx] <= 1'b1;
                if (hit_cnt_q != 16'hFFFF) hit_cnt_q <= hit_cnt_q + 16'd1;
            end
            if (state_q == S_FILL && ack_ok && last_beat) begin
                valid_q[miss_idx_q] <= 1'b1;
                dirty_q[miss_idx_q] <= 1'b0;
            end
        end
    end

    // Tag and data arrays: store hits and refill beats; never cleared by reset.
    always_ff @(posedge clk) begin
        if (hit_acc && cpu_we) data_q[{cpu_idx, cpu_off}] <= cpu_wdata;
        if (state_q == S_FILL && ack_ok) begin
            data_q[{miss_idx_q, beat_q}] <= mem_rdata;
            if (last_beat) tag_q[miss_idx_q] <= miss_tag_q;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a responding memory model with configurable
// ack delay, a beat log, and hand-computed expected values per access.
module tb_dcache_ctrl;
    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        stall;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;
    logic [15:0] hit_cnt, miss_cnt;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    dcache_ctrl #(.WD(32), .SETS(16), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .stall(stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_dbg(state_dbg)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Main memory model: untouched words read as 0xA0000000 | address.
    logic [31:0] mem_q [logic [31:0]];
    logic [31:0] log_addr[$];
    logic [31:0] log_wd[$];
    logic        log_we[$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    logic [31:0] hold_addr, hold_wd;
    logic        hold_we;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_q.exists(a)) return mem_q[a];
        return 32'hA000_0000 | a;
    endfunction

    // Responder: each beat waits ack_delay cycles, then acks; held fields are checked while waiting.
    always @(negedge clk) begin
        if (!rst || !mem_req) begin
            wait_cnt  = 0;
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end else begin
            if (wait_cnt == 0) begin
                hold_addr = mem_addr;
                hold_wd   = mem_wdata;
                hold_we   = mem_we;
            end else begin
                chk("hold_addr", mem_addr, hold_addr);
                chk("hold_wdata", mem_wdata, hold_wd);
                chk("hold_we", {31'd0, mem_we}, {31'd0, hold_we});
            end
            if (wait_cnt >= ack_delay) begin
                mem_ack = 1'b1;
                log_addr.push_back(mem_addr);
                log_wd.push_back(mem_wdata);
                log_we.push_back(mem_we);
                if (mem_we) mem_q[mem_addr] = mem_wdata;
                mem_rdata = mem_rd(mem_addr);
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Driver: one core access, called at posedge+1; returns stalled cycles and load data.
    task automatic access(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wd, output int stalls, output logic [31:0] rd);
        stalls = 0;
        rd = '0;
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!stall) begin
                rd = cpu_rdata;
                break;
            end
            stalls++;
        end
        if (stalls >= 200) chk({tag, "_timeout"}, 32'd1, 32'd0);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    // Scoreboard: compare the logged beats against an expected queue.
    logic [31:0] exp_q[$];
    logic [31:0] exp_wd_q[$];
    logic        exp_we_q[$];

    task automatic expect_beat(input logic we, input logic [31:0] addr, input logic [31:0] wd);
        exp_we_q.push_back(we);
        exp_q.push_back(addr);
        exp_wd_q.push_back(wd);
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_nbeats"}, log_addr.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_addr.size(); i++) begin
            chk($sformatf("%s_addr%0d", tag, i), log_addr[i], exp_q[i]);
            chk($sformatf("%s_we%0d", tag, i), {31'd0, log_we[i]}, {31'd0, exp_we_q[i]});
            if (exp_we_q[i]) chk($sformatf("%s_wd%0d", tag, i), log_wd[i], exp_wd_q[i]);
        end
        exp_q.delete(); exp_wd_q.delete(); exp_we_q.delete();
        log_addr.delete(); log_wd.delete(); log_we.delete();
    endtask

    task automatic expect_fill(input logic [31:0] base);
        for (int i = 0; i < 4; i++) expect_beat(1'b0, base + 32'(4 * i), '0);
    endtask

    int          st;
    logic [31:0] rd;
    bit          seen;

    initial begin
        rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_hit", {16'd0, hit_cnt}, 32'd0);
        chk("rst_miss", {16'd0, miss_cnt}, 32'd0);
        @(posedge clk); #1;

        // 1: clean miss, single-cycle ack
        access("t1", 1'b0, 32'h100, '0, st, rd);
        chk("t1_stall", st, 32'd5);
        chk("t1_rdata", rd, 32'hA000_0100);
        expect_fill(32'h100);
        check_beats("t1");
        chk("t1_miss", {16'd0, miss_cnt}, 32'd1);
        chk("t1_hit", {16'd0, hit_cnt}, 32'd1);

        // 2: hit in the same line
        access("t2", 1'b0, 32'h10C, '0, st, rd);
        chk("t2_stall", st, 32'd0);
        chk("t2_rdata", rd, 32'hA000_010C);
        chk("t2_hit", {16'd0, hit_cnt}, 32'd2);
        chk("t2_miss", {16'd0, miss_cnt}, 32'd1);

        // 3: store hit, then conflicting load forces writeback of the dirty line
        access("t3s", 1'b1, 32'h100, 32'hDEAD_BEEF, st, rd);
        chk("t3s_stall", st, 32'd0);
        chk("t3s_hit", {16'd0, hit_cnt}, 32'd3);
        access("t3", 1'b0, 32'h500, '0, st, rd);
        chk("t3_stall", st, 32'd9);
        chk("t3_rdata", rd, 32'hA000_0500);
        expect_beat(1'b1, 32'h100, 32'hDEAD_BEEF);
        expect_beat(1'b1, 32'h104, 32'hA000_0104);
        expect_beat(1'b1, 32'h108, 32'hA000_0108);
        expect_beat(1'b1, 32'h10C, 32'hA000_010C);
        expect_fill(32'h500);
        check_beats("t3");
        chk("t3_miss", {16'd0, miss_cnt}, 32'd2);
        chk("t3_hit", {16'd0, hit_cnt}, 32'd4);
        // The written-back store is visible in memory: clean miss re-reads it.
        access("t3r", 1'b0, 32'h100, '0, st, rd);
        chk("t3r_stall", st, 32'd5);
        chk("t3r_rdata", rd, 32'hDEAD_BEEF);
        expect_fill(32'h100);
        check_beats("t3r");

        // 4: three wait cycles per beat: 1 + 4*(3+1) stalled cycles
        ack_delay = 3;
        access("t4", 1'b0, 32'h200, '0, st, rd);
        chk("t4_stall", st, 32'd17);
        chk("t4_rdata", rd, 32'hA000_0200);
        expect_fill(32'h200);
        check_beats("t4");
        chk("t4_miss", {16'd0, miss_cnt}, 32'd4);
        ack_delay = 0;

        // 5: reset asserted during the third fill beat
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (log_addr.size() == 3) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("t5_timeout", 32'd1, 32'd0);
        rst = 1'b0; cpu_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t5_mem_addr", mem_addr, 32'd0);
        chk("t5_stall", {31'd0, stall}, 32'd0);
        chk("t5_state", {30'd0, state_dbg}, 32'd0);
        chk("t5_miss0", {16'd0, miss_cnt}, 32'd0);
        chk("t5_hit0", {16'd0, hit_cnt}, 32'd0);
        log_addr.delete(); log_wd.delete(); log_we.delete();
        @(posedge clk); #1;
        access("t5", 1'b0, 32'h100, '0, st, rd);
        chk("t5_stall_miss", st, 32'd5);
        chk("t5_rdata", rd, 32'hDEAD_BEEF);
        chk("t5_miss", {16'd0, miss_cnt}, 32'd1);
        expect_fill(32'h100);
        check_beats("t5");

        // 6: core drops its request during the fill; burst still completes
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h400;
        @(negedge clk);
        chk("t6_stall_miss", {31'd0, stall}, 32'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (log_addr.size() == 4) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("t6_timeout", 32'd1, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("t6_state", {30'd0, state_dbg}, 32'd0);
        chk("t6_stall", {31'd0, stall}, 32'd0);
        chk("t6_mem_req", {31'd0, mem_req}, 32'd0);
        chk("t6_miss", {16'd0, miss_cnt}, 32'd2);
        chk("t6_hit", {16'd0, hit_cnt}, 32'd1);
        expect_fill(32'h400);
        check_beats("t6");
        @(posedge clk); #1;
        access("t6h", 1'b0, 32'h400, '0, st, rd);
        chk("t6h_stall", st, 32'd0);
        chk("t6h_rdata", rd, 32'hA000_0400);
        chk("t6h_hit", {16'd0, hit_cnt}, 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench always ends on its own.
    initial begin
        #200000;
        chk("global_timeout", 32'd1, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "time limit reached");
    end
endmodule
